// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch-resolve wait and load-use stall sequencing.
// Optional stall-cycle counter is built only when HAZ_STALL_CNT_EN is defined.
module hazard_ctrl #(
    parameter int RA_W   = 3,
    parameter int BR_RES = 1,
    parameter int LD_LAT = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            state,
    input  logic            op_halt,
    input  logic            br_id,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic            op_mem_read_ex,
    input  logic [RA_W-1:0] rd_ex,
    input  logic [RA_W-1:0] rs_id,
    input  logic [RA_W-1:0] rd_id,
    input  logic            use_rs_id,
    input  logic            use_rd_id,
    output logic            op_pc_write,
    output logic            op_if_id_write,
    output logic            op_id_ex_write,
    output logic            op_if_id_flush,
    output logic            op_id_ex_flush,
    output logic            op_cc_write,
    output logic            br_timeout,
    output logic [15:0]     stall_cycles
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BR_WAIT  = 2'd1;
    localparam logic [1:0] ST_LU_STALL = 2'd2;
    localparam logic [1:0] BR_CNT0     = 2'(BR_RES - 1);
    localparam logic [1:0] LU_CNT0     = 2'(LD_LAT - 1);

    logic [1:0] fsm_q, fsm_d;
    logic [1:0] cnt_q, cnt_d;
    logic       en, load_use;
    logic       pat_freeze, pat_bubble, pat_flush, pat_normal, timeout;

    // Reset is folded into the enable so outputs are quiet during the reset cycle itself.
    assign en       = reset & state & ~op_halt;
    assign load_use = op_mem_read_ex &
                      ((use_rs_id & (rs_id == rd_ex)) | (use_rd_id & (rd_id == rd_ex)));

    always_comb begin
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        pat_freeze = 1'b0;
        pat_bubble = 1'b0;
        pat_flush  = 1'b0;
        pat_normal = 1'b0;
        timeout    = 1'b0;
        if (op_halt) begin
            fsm_d = ST_RUN;
            cnt_d = 2'd0;
        end else if (state) begin
            case (fsm_q)
                ST_RUN: begin
                    if (br_id) begin
                        pat_freeze = 1'b1;
                        fsm_d      = ST_BR_WAIT;
                        cnt_d      = BR_CNT0;
                    end else if (load_use) begin
                        pat_bubble = 1'b1;
                        if (LD_LAT > 1) begin
                            fsm_d = ST_LU_STALL;
                            cnt_d = LU_CNT0;
                        end
                    end else begin
                        pat_normal = 1'b1;
                    end
                end
                ST_BR_WAIT: begin
                    if (br_valid) begin
                        pat_flush  = br_taken;
                        pat_normal = ~br_taken;
                        fsm_d      = ST_RUN;
                        cnt_d      = 2'd0;
                    end else if (cnt_q != 2'd0) begin
                        pat_freeze = 1'b1;
                        cnt_d      = cnt_q - 2'd1;
                    end else begin
                        pat_normal = 1'b1;
                        timeout    = 1'b1;
                        fsm_d      = ST_RUN;
                    end
                end
                ST_LU_STALL: begin
                    // The RUN detect cycle is the first bubble, so leave once the count hits zero.
                    pat_bubble = 1'b1;
                    cnt_d      = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        fsm_d = ST_RUN;
                        cnt_d = 2'd0;
                    end
                end
                default: begin
                    fsm_d = ST_RUN;
                    cnt_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm_q <= ST_RUN;
            cnt_q <= 2'd0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
        end
    end

    assign op_pc_write    = en & (pat_normal | pat_flush);
    assign op_if_id_write = en & (pat_normal | pat_flush);
    assign op_id_ex_write = en & (pat_normal | pat_flush | pat_bubble);
    assign op_if_id_flush = en & pat_flush;
    assign op_id_ex_flush = en & pat_bubble;
    assign op_cc_write    = en & (pat_normal | pat_flush | pat_bubble | pat_freeze);
    assign br_timeout     = en & timeout;

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_q <= 16'd0;
        end else if (en && (pat_freeze || pat_bubble) && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default and BR_RES=3/LD_LAT=3) against a cycle model.
module tb_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset, state, op_halt, br_id, br_valid, br_taken, op_mem_read_ex;
    logic [2:0] rd_ex, rs_id, rd_id;
    logic       use_rs_id, use_rd_id;
    logic [6:0] outv [2];
    logic [15:0] stall [2];

    int checks = 0;
    int errors = 0;

    // model state: pending branch, remaining waits, remaining bubbles, stall count
    int br_pend [2];
    int br_left [2];
    int lu_left [2];
    int scnt    [2];
    int BRR     [2] = '{1, 3};
    int LDL     [2] = '{1, 3};

    always #5 clock = ~clock;

    hazard_ctrl u0 (
        .clock(clock), .reset(reset), .state(state), .op_halt(op_halt), .br_id(br_id),
        .br_valid(br_valid), .br_taken(br_taken), .op_mem_read_ex(op_mem_read_ex),
        .rd_ex(rd_ex), .rs_id(rs_id), .rd_id(rd_id), .use_rs_id(use_rs_id), .use_rd_id(use_rd_id),
        .op_pc_write(outv[0][6]), .op_if_id_write(outv[0][5]), .op_id_ex_write(outv[0][4]),
        .op_if_id_flush(outv[0][3]), .op_id_ex_flush(outv[0][2]), .op_cc_write(outv[0][1]),
        .br_timeout(outv[0][0]), .stall_cycles(stall[0])
    );

    hazard_ctrl #(.RA_W(3), .BR_RES(3), .LD_LAT(3)) u1 (
        .clock(clock), .reset(reset), .state(state), .op_halt(op_halt), .br_id(br_id),
        .br_valid(br_valid), .br_taken(br_taken), .op_mem_read_ex(op_mem_read_ex),
        .rd_ex(rd_ex), .rs_id(rs_id), .rd_id(rd_id), .use_rs_id(use_rs_id), .use_rd_id(use_rd_id),
        .op_pc_write(outv[1][6]), .op_if_id_write(outv[1][5]), .op_id_ex_write(outv[1][4]),
        .op_if_id_flush(outv[1][3]), .op_id_ex_flush(outv[1][2]), .op_cc_write(outv[1][1]),
        .br_timeout(outv[1][0]), .stall_cycles(stall[1])
    );

    // {pc, if_id, id_ex, if_id_flush, id_ex_flush, cc, timeout}; 0 off, 1 freeze, 2 bubble, 3 flush, 4 normal
    function automatic logic [6:0] pat(input int k, input bit to);
        logic [6:0] v;
        case (k)
            1:       v = 7'b0000010;
            2:       v = 7'b0010110;
            3:       v = 7'b1111010;
            4:       v = 7'b1110010;
            default: v = 7'b0000000;
        endcase
        v[0] = to;
        return v;
    endfunction

    task automatic idle();
        state = 1'b1; op_halt = 1'b0; br_id = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
        op_mem_read_ex = 1'b0; rd_ex = 3'd0; rs_id = 3'd0; rd_id = 3'd0;
        use_rs_id = 1'b0; use_rd_id = 1'b0;
    endtask

    // Check both instances at mid-cycle, advance the model, then step past the rising edge.
    task automatic cycle();
        bit lu;
        @(negedge clock);
        lu = op_mem_read_ex && ((use_rs_id && rs_id == rd_ex) || (use_rd_id && rd_id == rd_ex));
        for (int m = 0; m < 2; m++) begin
            int k;
            bit to;
            logic [15:0] es;
            logic [6:0]  ev;
            k  = 0;
            to = 1'b0;
`ifdef HAZ_STALL_CNT_EN
            es = 16'(scnt[m]);
`else
            es = 16'd0;
`endif
            checks++;
            assert (stall[m] === es) else begin
                errors++;
                $error("FAIL stall_cycles u%0d t=%0t got %0d want %0d", m, $time, stall[m], es);
            end
            if (!reset) begin
                br_pend[m] = 0; lu_left[m] = 0; scnt[m] = 0;
            end else if (op_halt) begin
                br_pend[m] = 0; lu_left[m] = 0;
            end else if (!state) begin
                k = 0;
            end else if (br_pend[m] != 0) begin
                if (br_valid) begin
                    k = br_taken ? 3 : 4; br_pend[m] = 0;
                end else if (br_left[m] > 0) begin
                    k = 1; br_left[m]--;
                end else begin
                    k = 4; to = 1'b1; br_pend[m] = 0;
                end
            end else if (lu_left[m] > 0) begin
                k = 2; lu_left[m]--;
            end else if (br_id) begin
                k = 1; br_pend[m] = 1; br_left[m] = BRR[m] - 1;
            end else if (lu) begin
                k = 2; lu_left[m] = LDL[m] - 1;
            end else begin
                k = 4;
            end
            if (reset && (k == 1 || k == 2) && scnt[m] < 65535) scnt[m]++;
            ev = pat(k, to);
            checks++;
            assert (outv[m] === ev) else begin
                errors++;
                $error("FAIL outputs u%0d t=%0t got %b want %b", m, $time, outv[m], ev);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic lu_set(input logic [2:0] r);
        op_mem_read_ex = 1'b1; rd_ex = r; rs_id = r; use_rs_id = 1'b1;
    endtask

    initial begin
        logic [15:0] want5;
        for (int m = 0; m < 2; m++) begin
            br_pend[m] = 0; br_left[m] = 0; lu_left[m] = 0; scnt[m] = 0;
        end
        idle();
        reset = 1'b0;
        br_id = 1'b1;
        #1;
        cycle();
        cycle();
        reset = 1'b1;
        idle();

        // taken branch resolved on the cycle after detect
        br_id = 1'b1; cycle();
        br_id = 1'b0; br_valid = 1'b1; br_taken = 1'b1; cycle();
        idle(); cycle();

        // no resolution: timeout path
        br_id = 1'b1; cycle();
        idle(); repeat (4) cycle();

        // load-use held for LD_LAT cycles, then dependency dropped
        lu_set(3'd5); repeat (3) cycle();
        use_rs_id = 1'b0; cycle();
        idle(); cycle();
        op_mem_read_ex = 1'b1; rd_ex = 3'd0; rd_id = 3'd0; use_rd_id = 1'b1; cycle();
        idle(); repeat (2) cycle();

        // halt during the stall
        lu_set(3'd5); cycle();
        idle(); op_halt = 1'b1; cycle();
        op_halt = 1'b0; cycle();

        // reset during branch wait, then a late br_valid must not flush
        br_id = 1'b1; cycle();
        br_id = 1'b0; reset = 1'b0; cycle();
        reset = 1'b1; br_valid = 1'b1; br_taken = 1'b1; cycle();
        idle(); cycle();

        // stopped CPU holds the branch wait
        br_id = 1'b1; cycle();
        br_id = 1'b0; state = 1'b0; repeat (3) cycle();
        state = 1'b1; br_valid = 1'b1; cycle();
        idle(); repeat (3) cycle();

        // 2 freeze + 3 bubble on the BR_RES=3/LD_LAT=3 instance
        reset = 1'b0; cycle();
        reset = 1'b1;
        br_id = 1'b1; cycle();
        br_id = 1'b0; cycle();
        br_valid = 1'b1; cycle();
        idle(); lu_set(3'd2); cycle();
        idle(); repeat (3) cycle();
        @(negedge clock);
`ifdef HAZ_STALL_CNT_EN
        want5 = 16'd5;
`else
        want5 = 16'd0;
`endif
        checks++;
        assert (stall[1] === want5) else begin
            errors++;
            $error("FAIL stall_total got %0d want %0d", stall[1], want5);
        end
        @(posedge clock); #1;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 49) != 0);
            state          = ($urandom_range(0, 9) != 0);
            op_halt        = ($urandom_range(0, 24) == 0);
            br_id          = ($urandom_range(0, 5) == 0);
            br_valid       = ($urandom_range(0, 3) == 0);
            br_taken       = 1'($urandom_range(0, 1));
            op_mem_read_ex = ($urandom_range(0, 2) == 0);
            rd_ex          = 3'($urandom_range(0, 3));
            rs_id          = 3'($urandom_range(0, 3));
            rd_id          = 3'($urandom_range(0, 3));
            use_rs_id      = 1'($urandom_range(0, 1));
            use_rd_id      = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 3: register-address width, legal 2..5.
REQ-002 SHALL have parameter BR_RES, default 1: maximum branch-resolve wait cycles, legal 1..4.
REQ-003 SHALL have parameter LD_LAT, default 1: load-use stall cycles, legal 1..4.
REQ-004 SHALL have port clock  in  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-low reset.
REQ-006 SHALL have port state  in  1: run enable; 0 = CPU stopped.
REQ-007 SHALL have port op_halt  in  1: halt instruction present.
REQ-008 SHALL have port br_id  in  1: conditional branch decoded in ID.
REQ-009 SHALL have port br_valid  in  1: branch outcome valid this cycle.
REQ-010 SHALL have port br_taken  in  1: branch taken; qualified by br_valid.
REQ-011 SHALL have port op_mem_read_ex  in  1: load in EX.
REQ-012 SHALL have port rd_ex  in  RA_W: load destination register in EX.
REQ-013 SHALL have ports rs_id and rd_id  in  RA_W each, plus use_rs_id and use_rd_id  in  1 each: ID source registers and their valid flags.
REQ-014 SHALL have outputs op_pc_write, op_if_id_write, op_id_ex_write, op_if_id_flush, op_id_ex_flush and op_cc_write, each 1 bit.
REQ-015 SHALL have outputs br_timeout  out  1 (one-cycle pulse) and stall_cycles  out  16.

Function
REQ-016 SHALL implement FSM states RUN, BR_WAIT and LU_STALL, with a down-counter cnt of width 2.
REQ-017 SHALL define output patterns:
- FREEZE: pc/if_id/id_ex write = 0, flushes = 0, cc_write = 1.
- BUBBLE: pc/if_id write = 0, id_ex_write = 1, id_ex_flush = 1, if_id_flush = 0, cc_write = 1.
- FLUSH: all writes = 1, if_id_flush = 1, id_ex_flush = 0, cc_write = 1.
- NORMAL: all writes = 1, flushes = 0, cc_write = 1.
REQ-018 SHALL drive all outputs 0 (except stall_cycles) whenever op_halt = 1 or state = 0, and SHALL force next state RUN with cnt = 0 on op_halt = 1.
REQ-019 SHALL hold FSM and cnt unchanged when state = 0 and op_halt = 0.
REQ-020 In RUN, SHALL apply priority br_id > load-use > NORMAL.
REQ-021 RUN with br_id = 1: FREEZE; next BR_WAIT; cnt = BR_RES-1.
REQ-022 SHALL detect load-use as op_mem_read_ex AND ((use_rs_id AND rs_id == rd_ex) OR (use_rd_id AND rd_id == rd_ex)), including register 0.
REQ-023 RUN with load-use and no br_id: BUBBLE; next LU_STALL with cnt = LD_LAT-1 when LD_LAT > 1, else remain RUN.
REQ-024 BR_WAIT transitions:
- br_valid AND br_taken: FLUSH, then RUN.
- br_valid AND NOT br_taken: NORMAL, then RUN.
- NOT br_valid AND cnt != 0: FREEZE, cnt decrements.
- NOT br_valid AND cnt == 0: NORMAL, br_timeout = 1, then RUN (treated as not taken).
REQ-025 In BR_WAIT, SHALL ignore load-use and br_id.
REQ-026 LU_STALL: BUBBLE; cnt decrements; at cnt == 0 next RUN; br_id and load-use SHALL be ignored until RUN.
REQ-027 br_valid in RUN or LU_STALL SHALL be ignored.
REQ-028 Total load-use stall SHALL be exactly LD_LAT cycles; total branch wait SHALL be at most BR_RES cycles after the detect cycle.

Reset
REQ-029 With reset = 0 at a rising edge: state RUN, cnt = 0, stall_cycles = 0.
REQ-030 While reset = 0, all single-bit outputs SHALL be 0, including in the reset cycle itself.
REQ-031 Reset mid-BR_WAIT or mid-LU_STALL SHALL abandon the operation, with no FLUSH and no br_timeout emitted.

Configuration
REQ-032 With macro HAZ_STALL_CNT_EN defined, stall_cycles SHALL count, saturating at 16'hFFFF, every enabled cycle (state = 1, op_halt = 0) whose pattern is FREEZE or BUBBLE; without the macro, stall_cycles SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-033 Defaults; br_id = 1 in cycle 0, br_valid = 1 and br_taken = 1 in cycle 1 -> cycle 0 FREEZE, cycle 1 FLUSH, cycle 2 NORMAL.
REQ-034 BR_RES = 3; br_id = 1, br_valid never asserted -> FREEZE for 3 cycles, then NORMAL with br_timeout = 1 for one cycle.
REQ-035 LD_LAT = 3; op_mem_read_ex = 1, rd_ex = 5, rs_id = 5, use_rs_id = 1 -> BUBBLE for 3 cycles, then NORMAL; with use_rs_id = 0 -> NORMAL.
REQ-036 op_halt = 1 while in LU_STALL -> all outputs 0 that cycle, RUN on the next cycle.
REQ-037 reset = 0 asserted during BR_WAIT -> outputs 0 and state RUN after the edge, no FLUSH.
REQ-038 HAZ_STALL_CNT_EN defined; 2 FREEZE cycles plus 3 BUBBLE cycles -> stall_cycles = 5; without the macro -> 0.
